// File: rtl/io_port_bridge.sv
// Bridges an external producer onto CPU input ports (one load per accept, stalled by CPU stores) and
// queues CPU stores to OUT_ADDR for an external consumer; stores arriving at a full queue are dropped and flagged.
module io_port_bridge #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [9:0] IN0_ADDR   = 10'h3F4,
   parameter logic [9:0] IN1_ADDR   = 10'h3F8,
   parameter logic [9:0] OUT_ADDR   = 10'h3FC,
   localparam int        PW         = $clog2(FIFO_DEPTH),
   localparam int        CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [9:0]    addr,
   input  logic          write_en,
   input  logic [31:0]   data_in,
   input  logic [31:0]   ext_in_data,
   input  logic          ext_in_sel,
   input  logic          ext_in_valid,
   output logic          ext_in_ready,
   output logic [31:0]   port_wdata,
   output logic          en_0,
   output logic          en_1,
   output logic [31:0]   ext_out_data,
   output logic          ext_out_valid,
   input  logic          ext_out_ready,
   output logic [CW-1:0] fifo_count,
   output logic          overflow
);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          sel_q, sel_d;
   logic          in_accept;

   assign in_accept  = ext_in_valid & ext_in_ready;
   assign port_wdata = wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wdata_q <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wdata_d = wdata_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (in_accept) begin
               state_d = LOAD;
               wdata_d = ext_in_data;
               sel_d   = ext_in_sel;
            end
         end
         LOAD: begin
            // Any CPU store owns the port-register write bus this cycle; retry next cycle.
            if (!write_en) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ext_in_ready = 1'b0;
      en_0         = 1'b0;
      en_1         = 1'b0;
      case (state_q)
         IDLE: ext_in_ready = !rst;
         LOAD: begin
            en_0 = !write_en && !sel_q;
            en_1 = !write_en &&  sel_q;
         end
         default: ;
      endcase
   end

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q;
   logic          in_port_hit, push_req, pop, full, push_acc, push_drop;

   // A store decoded as an input-port write never enters the queue, even if addresses are misconfigured to overlap.
   assign in_port_hit = (addr == IN0_ADDR) || (addr == IN1_ADDR);
   assign push_req    = write_en && (addr == OUT_ADDR) && !in_port_hit;
   assign full        = (count_q == CW'(FIFO_DEPTH));
   assign pop         = ext_out_valid && ext_out_ready;
   assign push_acc    = push_req && (!full || pop);
   assign push_drop   = push_req && full && !pop;

   always_comb begin
      count_d = count_q;
      case ({push_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push_acc) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (push_drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wptr_q] <= data_in;
      end
   end

   assign ext_out_valid = (count_q != '0);
   assign ext_out_data  = mem_q[rptr_q];
   assign fifo_count    = count_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: directed vector table, hand sequences for FIFO/reset corners, random run vs queue model.
module tb_io_port_bridge;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  addr = '0;
   logic        write_en = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] ext_in_data = '0;
   logic        ext_in_sel = 1'b0;
   logic        ext_in_valid = 1'b0;
   logic        ext_in_ready;
   logic [31:0] port_wdata;
   logic        en_0, en_1;
   logic [31:0] ext_out_data;
   logic        ext_out_valid;
   logic        ext_out_ready = 1'b0;
   logic [2:0]  fifo_count;
   logic        overflow;

   io_port_bridge #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .addr(addr), .write_en(write_en), .data_in(data_in),
      .ext_in_data(ext_in_data), .ext_in_sel(ext_in_sel), .ext_in_valid(ext_in_valid),
      .ext_in_ready(ext_in_ready), .port_wdata(port_wdata), .en_0(en_0), .en_1(en_1),
      .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model: output queue, sticky drop flag, and one pending port load.
   logic [31:0] mq[$];
   logic [31:0] popped[$];
   bit          m_busy, m_sel, m_ov;
   logic [31:0] m_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy  = 1'b0;
      m_sel   = 1'b0;
      m_ov    = 1'b0;
      m_wdata = '0;
   endtask

   task automatic model_check();
      chk("ready", 32'(ext_in_ready), 32'(!m_busy));
      chk("en_0", 32'(en_0), 32'(m_busy && !write_en && !m_sel));
      chk("en_1", 32'(en_1), 32'(m_busy && !write_en && m_sel));
      chk("port_wdata", port_wdata, m_wdata);
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("out_valid", 32'(ext_out_valid), 32'(mq.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ov));
      if (mq.size() != 0) chk("out_data", ext_out_data, mq[0]);
   endtask

   task automatic model_update();
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && ext_out_ready;
      do_push = write_en && (addr == 10'h3FC);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (mq.size() < DEPTH) mq.push_back(data_in);
         else m_ov = 1'b1;
      end
      if (m_busy) begin
         if (!write_en) m_busy = 1'b0;
      end else if (ext_in_valid) begin
         m_busy  = 1'b1;
         m_sel   = ext_in_sel;
         m_wdata = ext_in_data;
      end
   endtask

   task automatic drive(input logic wen, input logic [9:0] a, input logic [31:0] d,
                        input logic ev, input logic es, input logic [31:0] ed, input logic ordy);
      write_en = wen; addr = a; data_in = d;
      ext_in_valid = ev; ext_in_sel = es; ext_in_data = ed; ext_out_ready = ordy;
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step(input logic wen, input logic [9:0] a, input logic [31:0] d,
                       input logic ev, input logic es, input logic [31:0] ed, input logic ordy);
      drive(wen, a, d, ev, es, ed, ordy);
      @(negedge clk);
      model_check();
      if (ext_out_valid && ext_out_ready) popped.push_back(ext_out_data);
      finish_cycle();
   endtask

   task automatic do_reset();
      drive(0, 10'h0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      chk("rst_ready", 32'(ext_in_ready), 32'(0));
      chk("rst_en", 32'({en_1, en_0}), 32'(0));
      chk("rst_wdata", port_wdata, 32'(0));
      chk("rst_count", 32'(fifo_count), 32'(0));
      chk("rst_valid", 32'(ext_out_valid), 32'(0));
      chk("rst_ovf", 32'(overflow), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk("ready_after_rst", 32'(ext_in_ready), 32'(1));
   endtask

   typedef struct {
      logic        wen;
      logic [9:0]  a;
      logic        ev;
      logic        es;
      logic [31:0] ed;
      logic        x_rdy;
      logic        x_en0;
      logic        x_en1;
      logic [31:0] x_wdata;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Accept/load/retry timeline: each row is one cycle's inputs and the outputs expected during it.
      tbl[0]  = '{1'b0, 10'h000, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 10'h000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
      tbl[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hCAFEF00D};
      tbl[3]  = '{1'b0, 10'h000, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D};
      tbl[4]  = '{1'b1, 10'h3F4, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678};
      tbl[5]  = '{1'b1, 10'h3F8, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678};
      tbl[6]  = '{1'b1, 10'h3F4, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678};
      tbl[7]  = '{1'b0, 10'h000, 1'b1, 1'b1, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 32'h12345678};
      tbl[8]  = '{1'b0, 10'h000, 1'b1, 1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 32'h12345678};
      tbl[9]  = '{1'b0, 10'h000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hAAAA5555};
      tbl[10] = '{1'b0, 10'h000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hAAAA5555};

      model_reset();
      do_reset();

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].wen, tbl[i].a, 32'h0, tbl[i].ev, tbl[i].es, tbl[i].ed, 1'b0);
         @(negedge clk);
         model_check();
         chk($sformatf("tbl%0d_ready", i), 32'(ext_in_ready), 32'(tbl[i].x_rdy));
         chk($sformatf("tbl%0d_en0", i), 32'(en_0), 32'(tbl[i].x_en0));
         chk($sformatf("tbl%0d_en1", i), 32'(en_1), 32'(tbl[i].x_en1));
         chk($sformatf("tbl%0d_wdata", i), port_wdata, tbl[i].x_wdata);
         chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(0));
         finish_cycle();
      end

      // Five stores into a four-deep queue with the consumer stalled.
      popped.delete();
      for (int v = 1; v <= 5; v++) step(1, 10'h3FC, 32'(v), 0, 0, 0, 0);
      chk("ovf_fill_count", 32'(fifo_count), 32'(4));
      chk("ovf_fill_flag", 32'(overflow), 32'(1));
      for (int k = 0; k < 5; k++) step(0, 10'h0, 0, 0, 0, 0, 1);
      chk("ovf_drain_n", 32'(popped.size()), 32'(4));
      for (int k = 0; k < popped.size() && k < 4; k++) chk($sformatf("ovf_drain%0d", k), popped[k], 32'(k + 1));
      chk("ovf_drain_valid", 32'(ext_out_valid), 32'(0));
      chk("ovf_sticky", 32'(overflow), 32'(1));

      // Reset in the middle of a load with two entries queued.
      step(1, 10'h3FC, 32'h11, 0, 0, 0, 0);
      step(1, 10'h3FC, 32'h22, 1, 0, 32'h5A5A5A5A, 0);
      drive(0, 10'h0, 0, 0, 0, 0, 0);
      #1;
      chk("midload_en0", 32'(en_0), 32'(1));
      chk("midload_count", 32'(fifo_count), 32'(2));
      rst = 1'b1;
      #1;
      chk("abort_en", 32'({en_1, en_0}), 32'(0));
      chk("abort_count", 32'(fifo_count), 32'(0));
      chk("abort_valid", 32'(ext_out_valid), 32'(0));
      chk("abort_ovf", 32'(overflow), 32'(0));
      chk("abort_wdata", port_wdata, 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step(0, 10'h0, 0, 0, 0, 0, 0);

      // Push into a full queue on the same cycle as a pop.
      for (int v = 0; v < 4; v++) step(1, 10'h3FC, 32'hA1 + 32'(v), 0, 0, 0, 0);
      step(1, 10'h3FC, 32'h77, 0, 0, 0, 1);
      chk("fullpp_count", 32'(fifo_count), 32'(4));
      chk("fullpp_ovf", 32'(overflow), 32'(0));
      popped.delete();
      for (int k = 0; k < 5; k++) step(0, 10'h0, 0, 0, 0, 0, 1);
      chk("fullpp_n", 32'(popped.size()), 32'(4));
      if (popped.size() == 4) chk("fullpp_4th", popped[3], 32'h77);

      // Six pushes with a pop every other cycle: pointers wrap, order holds.
      popped.delete();
      for (int i = 0; i < 6; i++) step(1, 10'h3FC, 32'h100 + 32'(i), 0, 0, 0, 1'(i % 2));
      for (int k = 0; k < 6; k++) step(0, 10'h0, 0, 0, 0, 0, 1);
      chk("wrap_n", 32'(popped.size()), 32'(6));
      for (int k = 0; k < popped.size() && k < 6; k++) chk($sformatf("wrap%0d", k), popped[k], 32'h100 + 32'(k));
      chk("wrap_ovf", 32'(overflow), 32'(0));

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         logic [9:0] a;
         case ($urandom_range(0, 3))
            0: a = 10'h3F4;
            1: a = 10'h3F8;
            2: a = 10'h3FC;
            default: a = 10'($urandom);
         endcase
         step(1'($urandom_range(0, 2) == 0), a, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
